subtractor_serial: RTL and testbench
====================================

Name: subtractor_serial

Overview:
- Multi-cycle, chunk-serial unsigned/two's-complement subtractor: computes in0 - in1 as the inverse operation of the arithmetic-library adder.
- Processes CHUNK bits per cycle with a registered borrow chain. Trades latency for a short critical path.
- Sits in the arith library beside the combinational adder. Used in datapaths that accept a multi-cycle result behind a valid/ready handshake.

Parameters:
- WIDTH, 32: operand and difference width in bits; must be ≥ 1.
- CHUNK, 8: bits processed per cycle; must divide WIDTH exactly (elaboration-time assertion fails otherwise).
- NCHUNK, WIDTH/CHUNK: derived localparam (not overridable); number of compute cycles.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: block can accept operands.
- in0, input, WIDTH: minuend.
- in1, input, WIDTH: subtrahend.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- diff, output, WIDTH: (in0 - in1) mod 2^WIDTH.
- borrow, output, 1: 1 when in0 < in1 (unsigned).
- ovf, output, 1: signed overflow; operand signs differ and diff sign ≠ in0 sign.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; diff=0; borrow=0; ovf=0; chunk counter=0; internal operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in0/in1, clear borrow register and counter, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready=0; out_valid=0.
  - Each cycle, chunk k = counter (LSB chunk first): {b_next, d_k} = a_k - b_k - borrow_reg, computed CHUNK+1 bits wide.
  - d_k is written into diff[k*CHUNK +: CHUNK]; borrow_reg <= b_next; counter increments.
  - After chunk NCHUNK-1: go to DONE, borrow <= final b_next, ovf computed from latched operand MSBs and final diff MSB.
- DONE:
  - out_valid=1; in_ready=0; diff/borrow/ovf held stable.
  - On out_ready: go to IDLE.
  - Without out_ready: hold indefinitely (full backpressure, no result loss).
- Latency: acceptance at edge E, out_valid high after edge E+NCHUNK.
- Throughput: at most one operation per NCHUNK+2 cycles; no overlap of operations. in_ready is low in both RUN and DONE.
- Output stability:
  - diff/borrow/ovf are stable and valid only while out_valid=1.
  - diff shows partial results during RUN; consumers must not sample it then.
  - Outputs retain their last values in IDLE until the next RUN overwrites them.
- Input rules: in0/in1 are sampled only on the accept edge and may change at any time afterwards.
- Ignored inputs: in_valid is ignored in RUN/DONE; out_ready is ignored in IDLE/RUN.
- NCHUNK=1 (CHUNK=WIDTH): RUN lasts exactly one cycle.
- Wrap-around: modular arithmetic only; no saturation.
- Reset mid-operation: any state returns to IDLE immediately with outputs at reset values; the in-flight result is discarded.

Test Plan:
- WIDTH=8, CHUNK=4: in0=0x5A, in1=0x3C accepted → out_valid 2 cycles later; diff=0x1E, borrow=0, ovf=0.
- WIDTH=8, CHUNK=4: in0=0x10, in1=0x20 → diff=0xF0, borrow=1, ovf=0. Checks cross-chunk borrow propagation.
- WIDTH=8, CHUNK=4: in0=0x80, in1=0x01 → diff=0x7F, borrow=0, ovf=1. Also in0=0x00, in1=0x00 → diff=0x00, borrow=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → diff/borrow/ovf unchanged and in_ready=0 throughout. A new in_valid pulse during this time is not accepted. out_ready=1 → IDLE; in_ready=1 the next cycle.
- Reset mid-RUN: assert rst_n=0 after 1 of 2 chunks → out_valid=0, in_ready=1, diff=0 immediately. The next operation 0xFF-0x01 yields 0xFE, borrow=0.
- CHUNK=WIDTH=16: 0x0000-0x0001 → diff=0xFFFF, borrow=1, ovf=0, 1-cycle latency. Random back-to-back ops (≥1000) checked against a reference model.

Source files
------------

// File: rtl/subtractor_serial.sv
// subtractor_serial: chunk-serial subtractor computing in0 - in1 over NCHUNK
// cycles, CHUNK bits per cycle, with the borrow carried between chunks in a
// register. Operands are taken on a valid/ready handshake and the result is
// held behind out_valid until the consumer accepts it.
module subtractor_serial #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   // Reject geometries where the chunks do not tile the operand exactly.
   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
      $error("subtractor_serial: CHUNK must be >= 1 and divide WIDTH exactly");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [NCHUNK-1:0][CHUNK-1:0] a_reg;
   logic [NCHUNK-1:0][CHUNK-1:0] b_reg;
   logic [NCHUNK-1:0][CHUNK-1:0] diff_reg;
   logic [CW-1:0]                count;
   logic                         chain_borrow;
   logic                         borrow_reg;
   logic                         ovf_reg;
   logic [CHUNK:0]               chunk_diff;
   logic                         last_chunk;
   logic                         a_msb;
   logic                         b_msb;

   // One chunk of the subtraction, one bit wider so the top bit is the borrow out.
   always_comb begin
      chunk_diff = {1'b0, a_reg[count]} - {1'b0, b_reg[count]} - {{CHUNK{1'b0}}, chain_borrow};
      last_chunk = (count == CW'(NCHUNK - 1));
      a_msb      = a_reg[NCHUNK-1][CHUNK-1];
      b_msb      = b_reg[NCHUNK-1][CHUNK-1];
   end

   // State register; reset drops any in-flight operation back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs: accept only in IDLE, present only in DONE.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_chunk) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: latch operands on accept, then fill the difference one chunk per cycle LSB-first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg        <= '0;
         b_reg        <= '0;
         diff_reg     <= '0;
         count        <= '0;
         chain_borrow <= 1'b0;
         borrow_reg   <= 1'b0;
         ovf_reg      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg        <= in0;
                  b_reg        <= in1;
                  count        <= '0;
                  chain_borrow <= 1'b0;
               end
            end
            RUN: begin
               diff_reg[count] <= chunk_diff[CHUNK-1:0];
               chain_borrow    <= chunk_diff[CHUNK];
               if (last_chunk) begin
                  count      <= '0;
                  borrow_reg <= chunk_diff[CHUNK];
                  ovf_reg    <= (a_msb ^ b_msb) & (chunk_diff[CHUNK-1] ^ a_msb);
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign diff   = diff_reg;
   assign borrow = borrow_reg;
   assign ovf    = ovf_reg;

endmodule

// File: tb/tb_subtractor_serial.sv
// tb_subtractor_serial: exercises an 8-bit/4-bit-chunk instance and a
// 16-bit single-chunk instance with directed vectors and random traffic,
// checking every cycle against a transaction-level reference model.
module tb_subtractor_serial;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid_8 = 1'b0;
   logic        in_ready_8;
   logic [7:0]  in0_8 = '0;
   logic [7:0]  in1_8 = '0;
   logic        out_valid_8;
   logic        out_ready_8 = 1'b0;
   logic [7:0]  diff_8;
   logic        borrow_8;
   logic        ovf_8;

   logic        in_valid_16 = 1'b0;
   logic        in_ready_16;
   logic [15:0] in0_16 = '0;
   logic [15:0] in1_16 = '0;
   logic        out_valid_16;
   logic        out_ready_16 = 1'b0;
   logic [15:0] diff_16;
   logic        borrow_16;
   logic        ovf_16;

   int total = 0;
   int bad   = 0;

   // Reference model state: phase, remaining compute cycles, last result.
   int          ph8 = M_IDLE;
   int          left8 = 0;
   logic [7:0]  ed8 = '0;
   logic        eb8 = 1'b0;
   logic        eo8 = 1'b0;
   int          ph16 = M_IDLE;
   int          left16 = 0;
   logic [15:0] ed16 = '0;
   logic        eb16 = 1'b0;
   logic        eo16 = 1'b0;
   logic [17:0] r8;
   logic [17:0] r16;

   subtractor_serial #(.WIDTH(8), .CHUNK(4)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_8), .in_ready(in_ready_8),
      .in0(in0_8), .in1(in1_8),
      .out_valid(out_valid_8), .out_ready(out_ready_8),
      .diff(diff_8), .borrow(borrow_8), .ovf(ovf_8)
   );

   subtractor_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_16), .in_ready(in_ready_16),
      .in0(in0_16), .in1(in1_16),
      .out_valid(out_valid_16), .out_ready(out_ready_16),
      .diff(diff_16), .borrow(borrow_16), .ovf(ovf_16)
   );

   always #5 clk = ~clk;

   // Plain integer arithmetic: returns {ovf, borrow, diff} for a w-bit subtraction.
   function automatic logic [17:0] ref_sub(int w, logic [15:0] a, logic [15:0] b);
      int m, half, ia, ib, sa, sb, sd, d;
      logic bo, ov;
      m    = 1 << w;
      half = m / 2;
      ia   = int'(a);
      ib   = int'(b);
      d    = ((ia - ib) + m) % m;
      bo   = (ia < ib);
      sa   = (ia >= half) ? ia - m : ia;
      sb   = (ib >= half) ? ib - m : ib;
      sd   = sa - sb;
      ov   = (sd >= half) || (sd < -half);
      return {ov, bo, d[15:0]};
   endfunction

   assign r8  = ref_sub(8, {8'h00, in0_8}, {8'h00, in1_8});
   assign r16 = ref_sub(16, in0_16, in1_16);

   task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on the same edges as the DUT: accept, NCHUNK compute edges, then hold until taken.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph8 <= M_IDLE; left8 <= 0; ed8 <= '0; eb8 <= 1'b0; eo8 <= 1'b0;
         ph16 <= M_IDLE; left16 <= 0; ed16 <= '0; eb16 <= 1'b0; eo16 <= 1'b0;
      end else begin
         if (ph8 == M_IDLE && in_valid_8) begin
            ed8 <= r8[7:0]; eb8 <= r8[16]; eo8 <= r8[17];
            left8 <= 2; ph8 <= M_RUN;
         end else if (ph8 == M_RUN) begin
            if (left8 == 1) ph8 <= M_DONE;
            left8 <= left8 - 1;
         end else if (ph8 == M_DONE && out_ready_8) begin
            ph8 <= M_IDLE;
         end
         if (ph16 == M_IDLE && in_valid_16) begin
            ed16 <= r16[15:0]; eb16 <= r16[16]; eo16 <= r16[17];
            left16 <= 1; ph16 <= M_RUN;
         end else if (ph16 == M_RUN) begin
            if (left16 == 1) ph16 <= M_DONE;
            left16 <= left16 - 1;
         end else if (ph16 == M_DONE && out_ready_16) begin
            ph16 <= M_IDLE;
         end
      end
   end

   // Every cycle: handshake flags always, results whenever they are not mid-computation.
   always @(negedge clk) begin
      check_output("in_ready8", {31'b0, in_ready_8}, {31'b0, ph8 == M_IDLE});
      check_output("out_valid8", {31'b0, out_valid_8}, {31'b0, ph8 == M_DONE});
      if (ph8 != M_RUN) begin
         check_output("diff8", {24'b0, diff_8}, {24'b0, ed8});
         check_output("borrow8", {31'b0, borrow_8}, {31'b0, eb8});
         check_output("ovf8", {31'b0, ovf_8}, {31'b0, eo8});
      end
      check_output("in_ready16", {31'b0, in_ready_16}, {31'b0, ph16 == M_IDLE});
      check_output("out_valid16", {31'b0, out_valid_16}, {31'b0, ph16 == M_DONE});
      if (ph16 != M_RUN) begin
         check_output("diff16", {16'b0, diff_16}, {16'b0, ed16});
         check_output("borrow16", {31'b0, borrow_16}, {31'b0, eb16});
         check_output("ovf16", {31'b0, ovf_16}, {31'b0, eo16});
      end
   end

   task automatic apply_stimulus8(logic [7:0] a, logic [7:0] b);
      int lat;
      in0_8 = a;
      in1_8 = b;
      in_valid_8 = 1'b1;
      @(posedge clk); #1;
      in_valid_8 = 1'b0;
      lat = 0;
      while (!out_valid_8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_output("latency8", lat, 2);
   endtask

   task automatic release8();
      out_ready_8 = 1'b1;
      @(posedge clk); #1;
      out_ready_8 = 1'b0;
      check_output("in_ready8_after_take", {31'b0, in_ready_8}, 32'd1);
   endtask

   task automatic apply_stimulus16(logic [15:0] a, logic [15:0] b);
      int lat;
      in0_16 = a;
      in1_16 = b;
      in_valid_16 = 1'b1;
      @(posedge clk); #1;
      in_valid_16 = 1'b0;
      lat = 0;
      while (!out_valid_16 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_output("latency16", lat, 1);
   endtask

   task automatic random_ops8(int n);
      logic [7:0] corners [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
      int guard;
      out_ready_8 = 1'b1;
      for (int i = 0; i < n; i++) begin
         in0_8 = (i < 16) ? corners[i % 4] : 8'($urandom);
         in1_8 = (i < 16) ? corners[i / 4] : 8'($urandom);
         in_valid_8 = 1'b1;
         guard = 0;
         while (!in_ready_8 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 10) check_output("accept_timeout8", 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      in_valid_8 = 1'b0;
      repeat (5) @(posedge clk);
      #1 out_ready_8 = 1'b0;
   endtask

   task automatic random_ops16(int n);
      logic [15:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
      int guard;
      out_ready_16 = 1'b1;
      for (int i = 0; i < n; i++) begin
         in0_16 = (i < 16) ? corners[i % 4] : 16'($urandom);
         in1_16 = (i < 16) ? corners[i / 4] : 16'($urandom);
         in_valid_16 = 1'b1;
         guard = 0;
         while (!in_ready_16 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 10) check_output("accept_timeout16", 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      in_valid_16 = 1'b0;
      repeat (4) @(posedge clk);
      #1 out_ready_16 = 1'b0;
   endtask

   // Safety net so a stuck handshake can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence followed by random back-to-back traffic.
   initial begin
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_in_ready", {31'b0, in_ready_8}, 32'd1);
      check_output("reset_out_valid", {31'b0, out_valid_8}, 32'd0);
      check_output("reset_diff", {24'b0, diff_8}, 32'd0);
      check_output("reset_borrow", {31'b0, borrow_8}, 32'd0);
      check_output("reset_ovf", {31'b0, ovf_8}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply_stimulus8(8'h5A, 8'h3C);
      check_output("5A-3C diff", {24'b0, diff_8}, 32'h1E);
      check_output("5A-3C borrow", {31'b0, borrow_8}, 32'd0);
      check_output("5A-3C ovf", {31'b0, ovf_8}, 32'd0);
      release8();

      apply_stimulus8(8'h80, 8'h01);
      check_output("80-01 diff", {24'b0, diff_8}, 32'h7F);
      check_output("80-01 borrow", {31'b0, borrow_8}, 32'd0);
      check_output("80-01 ovf", {31'b0, ovf_8}, 32'd1);
      release8();

      apply_stimulus8(8'h00, 8'h00);
      check_output("00-00 diff", {24'b0, diff_8}, 32'h00);
      check_output("00-00 borrow", {31'b0, borrow_8}, 32'd0);
      check_output("00-00 ovf", {31'b0, ovf_8}, 32'd0);
      release8();

      apply_stimulus8(8'h10, 8'h20);
      check_output("10-20 diff", {24'b0, diff_8}, 32'hF0);
      check_output("10-20 borrow", {31'b0, borrow_8}, 32'd1);
      check_output("10-20 ovf", {31'b0, ovf_8}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         in_valid_8 = 1'b1;
         in0_8 = 8'h33;
         in1_8 = 8'h11;
         @(posedge clk); #1;
         check_output("hold diff", {24'b0, diff_8}, 32'hF0);
         check_output("hold borrow", {31'b0, borrow_8}, 32'd1);
         check_output("hold in_ready", {31'b0, in_ready_8}, 32'd0);
         check_output("hold out_valid", {31'b0, out_valid_8}, 32'd1);
      end
      in_valid_8 = 1'b0;
      release8();

      in0_8 = 8'hAB;
      in1_8 = 8'h12;
      in_valid_8 = 1'b1;
      @(posedge clk); #1;
      in_valid_8 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_output("midrun out_valid", {31'b0, out_valid_8}, 32'd0);
      check_output("midrun in_ready", {31'b0, in_ready_8}, 32'd1);
      check_output("midrun diff", {24'b0, diff_8}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      apply_stimulus8(8'hFF, 8'h01);
      check_output("FF-01 diff", {24'b0, diff_8}, 32'hFE);
      check_output("FF-01 borrow", {31'b0, borrow_8}, 32'd0);
      release8();

      apply_stimulus16(16'h0000, 16'h0001);
      check_output("0-1 diff16", {16'b0, diff_16}, 32'hFFFF);
      check_output("0-1 borrow16", {31'b0, borrow_16}, 32'd1);
      check_output("0-1 ovf16", {31'b0, ovf_16}, 32'd0);
      out_ready_16 = 1'b1;
      @(posedge clk); #1;
      out_ready_16 = 1'b0;
      check_output("in_ready16_after_take", {31'b0, in_ready_16}, 32'd1);

      random_ops8(300);
      random_ops16(1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
